// File: rtl/tone_scheduler.sv
// tone_scheduler: single-clock key-to-tone controller.
//   Synchronises and debounces four keys, arbitrates them into one note and
//   steps a sample-ROM address at FREQ*SAMPLE_SIZE Hz with a one-cycle strobe.
//   Note changes are deferred to the waveform wrap so the output never glitches.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   keys[3:0]    raw keys: bit0 SOL, bit1 MI, bit2 RE, bit3 DO
//   sample_addr  ROM address, $clog2(SAMPLE_SIZE) bits
//   sample_stb   one-cycle pulse when sample_addr takes a new value
//   note_id      current note: 0 DO, 1 RE, 2 MI, 3 SOL
//   playing      high while a note is sounding (PLAY or SWITCH)
//   switching    high while a note change waits for the wrap
module tone_scheduler #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned SAMPLE_SIZE     = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned DO_FEQ          = 523,
    parameter int unsigned RE_FEQ          = 587,
    parameter int unsigned MI_FEQ          = 659,
    parameter int unsigned SOL_FEQ         = 784
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [3:0]                     keys,
    output logic [$clog2(SAMPLE_SIZE)-1:0] sample_addr,
    output logic                           sample_stb,
    output logic [1:0]                     note_id,
    output logic                           playing,
    output logic                           switching
);
    localparam int unsigned AW      = $clog2(SAMPLE_SIZE);
    localparam int unsigned TW      = 16;
    localparam int unsigned DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PER_DO  = CLK_HZ / (DO_FEQ  * SAMPLE_SIZE);
    localparam int unsigned PER_RE  = CLK_HZ / (RE_FEQ  * SAMPLE_SIZE);
    localparam int unsigned PER_MI  = CLK_HZ / (MI_FEQ  * SAMPLE_SIZE);
    localparam int unsigned PER_SOL = CLK_HZ / (SOL_FEQ * SAMPLE_SIZE);
    localparam int unsigned PER_MAX = (1 << TW) - 1;

    // Elaboration-time sanity of the derived constants
    if (PER_DO < 2 || PER_RE < 2 || PER_MI < 2 || PER_SOL < 2) begin : g_period_min
        $error("tone_scheduler: every note period must be at least 2 clocks");
    end
    if (PER_DO > PER_MAX || PER_RE > PER_MAX || PER_MI > PER_MAX || PER_SOL > PER_MAX) begin : g_period_max
        $error("tone_scheduler: note period exceeds tick counter range");
    end
    if (SAMPLE_SIZE < 2 || (SAMPLE_SIZE & (SAMPLE_SIZE - 1)) != 0) begin : g_sample_size
        $error("tone_scheduler: SAMPLE_SIZE must be a power of two >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce
        $error("tone_scheduler: DEBOUNCE_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SWITCH} state_t;

    logic [3:0]    sync1, sync2, key_db;
    logic [DW-1:0] db_cnt;
    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d, period_cur;
    logic [AW-1:0] addr_d;
    logic [1:0]    note_d, req_note;
    logic          stb_d, playing_d, switching_d;
    logic          req_valid, req_none, wrap_tick, addr_end;

    // Synchroniser and debouncer; a change of the synced value (sync1 != sync2)
    // restarts the stability count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            key_db <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            if (sync1 != sync2 || sync2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                key_db <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // Key arbitration: only a single pressed key is a valid request
    always_comb begin
        req_none  = (key_db == 4'b0000);
        req_valid = 1'b1;
        req_note  = 2'd0;
        case (key_db)
            4'b1000: req_note = 2'd0;
            4'b0100: req_note = 2'd1;
            4'b0010: req_note = 2'd2;
            4'b0001: req_note = 2'd3;
            default: req_valid = 1'b0;
        endcase
    end

    // Period of the note currently sounding
    always_comb begin
        case (note_id)
            2'd0:    period_cur = TW'(PER_DO);
            2'd1:    period_cur = TW'(PER_RE);
            2'd2:    period_cur = TW'(PER_MI);
            default: period_cur = TW'(PER_SOL);
        endcase
    end

    assign wrap_tick = (tick_q == period_cur - TW'(1));
    assign addr_end  = (sample_addr == AW'(SAMPLE_SIZE - 1));

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        note_d  = note_id;
        addr_d  = sample_addr;
        tick_d  = tick_q;
        stb_d   = 1'b0;

        // Playback advances identically in PLAY and SWITCH
        if (state_q != S_IDLE) begin
            if (wrap_tick) begin
                tick_d = '0;
                addr_d = sample_addr + AW'(1);
                stb_d  = 1'b1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                tick_d = '0;
                if (req_valid) begin
                    note_d  = req_note;
                    stb_d   = 1'b1;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (req_none || (req_valid && req_note != note_id)) begin
                    state_d = S_SWITCH;
                end
            end
            S_SWITCH: begin
                // Resolve the pending change on the strobe that wraps to addr 0
                if (wrap_tick && addr_end) begin
                    if (req_valid) begin
                        note_d  = req_note;
                        state_d = S_PLAY;
                    end else if (req_none) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PLAY;
                    end
                end else if (req_valid && req_note == note_id) begin
                    state_d = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        playing_d   = (state_d != S_IDLE);
        switching_d = (state_d == S_SWITCH);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            note_id     <= '0;
            sample_addr <= '0;
            sample_stb  <= 1'b0;
            playing     <= 1'b0;
            switching   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            note_id     <= note_d;
            sample_addr <= addr_d;
            sample_stb  <= stb_d;
            playing     <= playing_d;
            switching   <= switching_d;
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler: randomized scenario bench for tone_scheduler with a
// behavioural reference model (debounce window + waveform-position arithmetic).
module tb_tone_scheduler;
    localparam int unsigned CLK_HZ = 167_360;
    localparam int unsigned SS     = 32;
    localparam int unsigned DB     = 4;
    localparam int unsigned AW     = 5;

    logic          clk;
    logic          rst_n;
    logic [3:0]    keys;
    logic [AW-1:0] sample_addr;
    logic          sample_stb;
    logic [1:0]    note_id;
    logic          playing;
    logic          switching;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    int unsigned   freq [4];
    logic [3:0]    rawq [$];
    logic [3:0]    m_kdb;
    bit            m_play;
    bit            m_pend;
    logic [1:0]    m_note;
    int            m_elapsed;
    logic [9:0]    exp_vec;
    logic [9:0]    obs;

    assign obs = {playing, switching, note_id, sample_stb, sample_addr};

    tone_scheduler #(
        .CLK_HZ          (CLK_HZ),
        .SAMPLE_SIZE     (SS),
        .DEBOUNCE_CYCLES (DB),
        .DO_FEQ          (523),
        .RE_FEQ          (587),
        .MI_FEQ          (659),
        .SOL_FEQ         (784)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keys        (keys),
        .sample_addr (sample_addr),
        .sample_stb  (sample_stb),
        .note_id     (note_id),
        .playing     (playing),
        .switching   (switching)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int period(input logic [1:0] n);
        return int'(CLK_HZ / (freq[n] * SS));
    endfunction

    function automatic bit is_onehot(input logic [3:0] k);
        return (k != 4'd0) && ((k & (k - 4'd1)) == 4'd0);
    endfunction

    // bit3 is DO (note 0) down to bit0 SOL (note 3)
    function automatic logic [1:0] note_of(input logic [3:0] k);
        for (int i = 0; i < 4; i++) begin
            if (k[3-i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic bit wants_change(input logic [3:0] req, input logic [1:0] cur);
        return (req == 4'd0) || (is_onehot(req) && note_of(req) != cur);
    endfunction

    task automatic model_reset();
        m_kdb     = 4'd0;
        m_play    = 1'b0;
        m_pend    = 1'b0;
        m_note    = 2'd0;
        m_elapsed = 0;
        rawq      = {};
        for (int i = 0; i <= int'(DB); i++) rawq.push_back(4'd0);
    endtask

    // Drive one cycle of keys, advance the model and leave expected outputs in exp_vec
    task automatic step(input logic [3:0] k);
        logic [3:0]    req;
        bit            win_ok;
        bit            stb;
        int            p;
        logic [AW-1:0] addr;
        keys = k;
        @(posedge clk);
        #1;
        cyc++;
        req = m_kdb;
        stb = 1'b0;
        if (!m_play) begin
            if (is_onehot(req)) begin
                m_play    = 1'b1;
                m_note    = note_of(req);
                m_elapsed = 0;
                m_pend    = 1'b0;
                stb       = 1'b1;
            end
        end else begin
            m_elapsed++;
            p   = period(m_note);
            stb = (m_elapsed % p == 0);
            if (m_elapsed == int'(SS) * p) begin
                m_elapsed = 0;
                if (m_pend) begin
                    m_pend = 1'b0;
                    if (is_onehot(req)) m_note = note_of(req);
                    else if (req == 4'd0) m_play = 1'b0;
                end else if (wants_change(req, m_note)) begin
                    m_pend = 1'b1;
                end
            end else if (!m_pend && wants_change(req, m_note)) begin
                m_pend = 1'b1;
            end else if (m_pend && is_onehot(req) && note_of(req) == m_note) begin
                m_pend = 1'b0;
            end
        end
        addr = '0;
        if (m_play) addr = AW'(m_elapsed / period(m_note));
        exp_vec = {m_play, m_pend, m_note, stb, addr};
        // Debounced value follows DB+1 identical raw samples seen through the 2-stage sync
        win_ok = 1'b1;
        for (int i = 1; i < rawq.size(); i++) begin
            if (rawq[i] !== rawq[0]) win_ok = 1'b0;
        end
        if (win_ok && rawq[0] !== m_kdb) m_kdb = rawq[0];
        rawq.push_back(k);
        if (rawq.size() > int'(DB) + 1) void'(rawq.pop_front());
    endtask

    task automatic test_reset();
        logic [3:0] k;
        int n;
        rst_n = 1'b0;
        keys  = 4'd0;
        #1;
        checks++;
        if (obs !== 10'd0) begin
            failures++;
            $display("FAIL reset_initial got=%b exp=%b", obs, 10'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        k = 4'(8 >> $urandom_range(0, 3));
        n = $urandom_range(20, 80);
        for (int i = 0; i < n; i++) begin
            step(k);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL reset_play cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
            end
        end
        checks++;
        if (playing !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_playing got=%b exp=1", playing);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 10'd0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", obs, 10'd0);
        end
        @(posedge clk);
        #1;
        keys  = 4'd0;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            step(4'd0);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL reset_after cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] k, cur;
        int per;
        bit any_play;
        k        = 4'(1 << $urandom_range(0, 3));
        per      = $urandom_range(1, 3);
        cur      = k;
        any_play = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(i < 30 ? cur : 4'd0);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL bounce_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
            end
            if (playing) any_play = 1'b1;
            if ((i + 1) % per == 0) cur = (cur == 4'd0) ? k : 4'd0;
        end
        checks++;
        if (any_play) begin
            failures++;
            $display("FAIL bounce_playing got=1 exp=0 per=%0d", per);
        end
    endtask

    task automatic test_first_note();
        int first, last, nstb;
        first = -1;
        last  = -1;
        nstb  = 0;
        for (int i = 1; i <= 7 + 33 * 10; i++) begin
            step(4'b1000);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL do_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
            end
            if (sample_stb) begin
                if (first < 0) begin
                    first = i;
                end else begin
                    checks++;
                    if (i - last != 10) begin
                        failures++;
                        $display("FAIL do_spacing got=%0d exp=10", i - last);
                    end
                end
                if (nstb == 31 || nstb == 32) begin
                    checks++;
                    if (sample_addr !== AW'(nstb % 32)) begin
                        failures++;
                        $display("FAIL do_wrap_addr strobe=%0d got=%0d exp=%0d", nstb, sample_addr, nstb % 32);
                    end
                end
                last = i;
                nstb++;
            end
        end
        checks++;
        if (first != 7) begin
            failures++;
            $display("FAIL do_latency got=%0d exp=7", first);
        end
    endtask

    task automatic test_switch();
        bit found, seen, saw_sw;
        int gap;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(4'b1000);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL switch_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
            end
            if (sample_stb && sample_addr == AW'(5)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL switch_wait_addr5 got=timeout exp=strobe");
        end
        seen   = 1'b0;
        saw_sw = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            step(4'b0001);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL switch_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
            end
            if (switching) saw_sw = 1'b1;
            if (sample_stb && note_id == 2'd3) begin
                seen = 1'b1;
                checks++;
                if (sample_addr !== '0) begin
                    failures++;
                    $display("FAIL switch_wrap_addr got=%0d exp=0", sample_addr);
                end
            end
        end
        checks++;
        if (!seen || !saw_sw) begin
            failures++;
            $display("FAIL switch_to_sol got seen=%b switching=%b exp seen=1 switching=1", seen, saw_sw);
        end
        gap = 0;
        do begin
            step(4'b0001);
            gap++;
        end while (!sample_stb && gap < 20);
        checks++;
        if (gap != 6) begin
            failures++;
            $display("FAIL switch_sol_spacing got=%0d exp=6", gap);
        end
    endtask

    task automatic test_return();
        bit ready, saw_sw;
        int last, r;
        ready = 1'b0;
        last  = -1;
        for (int i = 0; i < 600 && !ready; i++) begin
            step(4'b0010);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL return_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
            end
            if (playing && !switching && note_id == 2'd2) begin
                ready = 1'b1;
                last  = cyc;
            end
        end
        checks++;
        if (!ready) begin
            failures++;
            $display("FAIL return_wait_mi got=timeout exp=MI");
        end
        saw_sw = 1'b0;
        r = $urandom_range(6, 12);
        for (int i = 0; i < 20 + r + 40; i++) begin
            step((i >= 20 && i < 20 + r) ? 4'd0 : 4'b0010);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL return_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
            end
            if (switching) saw_sw = 1'b1;
            if (sample_stb) begin
                checks++;
                if (cyc - last != 7) begin
                    failures++;
                    $display("FAIL return_spacing got=%0d exp=7", cyc - last);
                end
                last = cyc;
            end
        end
        checks++;
        if (!saw_sw || switching !== 1'b0 || note_id !== 2'd2) begin
            failures++;
            $display("FAIL return_end got saw_sw=%b sw=%b note=%0d exp saw_sw=1 sw=0 note=2", saw_sw, switching, note_id);
        end
    endtask

    task automatic test_release();
        bit ready, done;
        int nstb;
        bit any_play;
        ready = 1'b0;
        for (int i = 0; i < 600 && !ready; i++) begin
            step(4'b0100);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL release_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
            end
            if (playing && !switching && note_id == 2'd1) ready = 1'b1;
        end
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step(4'd0);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL release_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
            end
            if (!playing) begin
                done = 1'b1;
                checks++;
                if (sample_stb !== 1'b1 || sample_addr !== '0) begin
                    failures++;
                    $display("FAIL release_last_stb got stb=%b addr=%0d exp stb=1 addr=0", sample_stb, sample_addr);
                end
            end
        end
        checks++;
        if (!ready || !done) begin
            failures++;
            $display("FAIL release_wait got ready=%b done=%b exp 1 1", ready, done);
        end
        nstb = 0;
        for (int i = 0; i < 30; i++) begin
            step(4'd0);
            if (sample_stb) nstb++;
        end
        checks++;
        if (nstb != 0) begin
            failures++;
            $display("FAIL release_idle_stb got=%0d exp=0", nstb);
        end
        any_play = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(4'b0011);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL multikey_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
            end
            if (playing) any_play = 1'b1;
        end
        checks++;
        if (any_play) begin
            failures++;
            $display("FAIL multikey_idle got=1 exp=0");
        end
    endtask

    task automatic test_random();
        logic [3:0] k;
        int sel, len;
        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 9);
            len = $urandom_range(1, 150);
            if (sel < 2)      k = 4'd0;
            else if (sel < 7) k = 4'(1 << $urandom_range(0, 3));
            else              k = 4'($urandom_range(0, 15));
            for (int i = 0; i < len; i++) begin
                if (sel == 9) k = 4'($urandom_range(0, 15));
                step(k);
                checks++;
                if (obs !== exp_vec) begin
                    failures++;
                    $display("FAIL random_model cyc=%0d keys=%b got=%b exp=%b", cyc, k, obs, exp_vec);
                end
            end
        end
    endtask

    initial begin
        freq  = '{523, 587, 659, 784};
        rst_n = 1'b0;
        keys  = 4'd0;
        model_reset();
        test_reset();
        test_bounce();
        test_first_note();
        test_switch();
        test_return();
        test_release();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
